// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIF FFT butterfly scheduler.
package fft_pkg;

  localparam int STAGE_W      = 4;
  localparam int LOG2N_MIN    = 2;
  localparam int LOG2N_MAX    = 10;
  localparam int BITREV_MAX_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_UNLOAD,
    S_DONE
  } sched_state_e;

  // Reverses the low `width` bits of x; bits at and above `width` come back as 0.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                     input int width);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < width) r[i] = x[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth shift pipeline that turns the read-issue stream into the
// matching write-back stream; flush empties it in one cycle.
module fft_wb_delay #(
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  output logic          out_valid,
  output logic [AW-1:0] out_addr_a,
  output logic [AW-1:0] out_addr_b
);

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    addr_a_q [DEPTH];
  logic [AW-1:0]    addr_b_q [DEPTH];

  // NOTE: the address stages are reset along with valid so that the
  // write-back address outputs read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_a_q[i] <= '0;
        addr_b_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_a_q[i] <= '0;
        addr_b_q[i] <= '0;
      end
    end else begin
      valid_q     <= {valid_q[DEPTH-2:0], in_valid};
      addr_a_q[0] <= in_addr_a;
      addr_b_q[0] <= in_addr_b;
      for (int i = 1; i < DEPTH; i++) begin
        addr_a_q[i] <= addr_a_q[i-1];
        addr_b_q[i] <= addr_b_q[i-1];
      end
    end
  end

  assign out_valid  = valid_q[DEPTH-1];
  assign out_addr_a = addr_a_q[DEPTH-1];
  assign out_addr_b = addr_b_q[DEPTH-1];

endmodule

// File: rtl/fft_btf_sched.sv
// In-place DIF FFT butterfly issue sequencer with write-back regeneration.
// Optional bit-reversed unload phase enabled by macro FFT_SCHED_BITREV_EN.
module fft_btf_sched
  import fft_pkg::*;
#(
  parameter int LOG2N   = 3,
  parameter int BTF_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [LOG2N-1:0]   rd_addr_a,
  output logic [LOG2N-1:0]   rd_addr_b,
  output logic [LOG2N-2:0]   tw_idx,
  output logic               wr_en,
  output logic [LOG2N-1:0]   wr_addr_a,
  output logic [LOG2N-1:0]   wr_addr_b,
  output logic               ul_valid,
  output logic [LOG2N-1:0]   ul_addr,
  output logic [LOG2N-1:0]   ul_idx
);

  localparam int N        = 1 << LOG2N;
  localparam int TW_W     = LOG2N - 1;
  localparam int WB_DEPTH = 1 + BTF_LAT;
  localparam int DRAIN_W  = $clog2(WB_DEPTH) + 1;

  if (LOG2N < LOG2N_MIN || LOG2N > LOG2N_MAX) begin : g_bad_log2n
    $error("fft_btf_sched: LOG2N out of range");
  end
  if (BTF_LAT < 1) begin : g_bad_lat
    $error("fft_btf_sched: BTF_LAT must be at least 1");
  end

  sched_state_e       state_q, state_d;
  logic [STAGE_W-1:0] stage_q;
  logic [LOG2N-1:0]   k_q, g_q;
  logic [DRAIN_W-1:0] drain_q;

  logic [LOG2N-1:0] span, grp_m1, g_base, addr_a, addr_b;
  int               shamt;
  logic             issuing, last_k, issue_last, drain_last, final_stage, ul_last;

  always_comb begin
    span        = LOG2N'((N / 2) >> stage_q);
    grp_m1      = LOG2N'((1 << stage_q) - 1);
    shamt       = LOG2N - int'(stage_q);
    g_base      = g_q << shamt;
    addr_a      = g_base + k_q;
    addr_b      = addr_a + span;
    issuing     = (state_q == S_ISSUE);
    last_k      = (k_q == span - LOG2N'(1));
    issue_last  = issuing && last_k && (g_q == grp_m1);
    drain_last  = (state_q == S_DRAIN) && (drain_q == DRAIN_W'(WB_DEPTH - 1));
    final_stage = (stage_q == STAGE_W'(LOG2N - 1));
  end

`ifdef FFT_SCHED_BITREV_EN
  logic [LOG2N-1:0] ul_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ul_idx_q <= '0;
    else if (state_q != S_UNLOAD) ul_idx_q <= '0;
    else                         ul_idx_q <= ul_idx_q + LOG2N'(1);
  end

  assign ul_last  = (ul_idx_q == LOG2N'(N - 1));
  assign ul_valid = (state_q == S_UNLOAD);
  assign ul_idx   = ul_valid ? ul_idx_q : '0;
  assign ul_addr  = ul_valid ? LOG2N'(bitrev(BITREV_MAX_W'(ul_idx_q), LOG2N)) : '0;
`else
  assign ul_last  = 1'b0;
  assign ul_valid = 1'b0;
  assign ul_idx   = '0;
  assign ul_addr  = '0;
`endif

  // NOTE: state_d gets its default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (issue_last) state_d = S_DRAIN;
      S_DRAIN: begin
        if (drain_last) begin
          if (!final_stage) state_d = S_ISSUE;
`ifdef FFT_SCHED_BITREV_EN
          else state_d = S_UNLOAD;
`else
          else state_d = S_DONE;
`endif
        end
      end
      S_UNLOAD: if (ul_last) state_d = S_DONE;
                else state_d = ul_valid ? S_UNLOAD : S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a start seen in IDLE.
    if (abort) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      k_q     <= '0;
      g_q     <= '0;
      drain_q <= '0;
    end else if (state_d == S_IDLE) begin
      stage_q <= '0;
      k_q     <= '0;
      g_q     <= '0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        S_ISSUE: begin
          drain_q <= '0;
          if (issue_last) begin
            k_q <= '0;
            g_q <= '0;
          end else if (last_k) begin
            k_q <= '0;
            g_q <= g_q + LOG2N'(1);
          end else begin
            k_q <= k_q + LOG2N'(1);
          end
        end
        S_DRAIN: begin
          if (drain_last) begin
            drain_q <= '0;
            if (!final_stage) stage_q <= stage_q + STAGE_W'(1);
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Addresses are forced to 0 outside ISSUE so idle cycles carry clean zeros.
  assign rd_en     = issuing;
  assign rd_addr_a = issuing ? addr_a : '0;
  assign rd_addr_b = issuing ? addr_b : '0;
  assign tw_idx    = issuing ? TW_W'(k_q << stage_q) : '0;
  assign stage     = stage_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  fft_wb_delay #(
    .DEPTH (WB_DEPTH),
    .AW    (LOG2N)
  ) u_wb_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (abort),
    .in_valid   (rd_en),
    .in_addr_a  (rd_addr_a),
    .in_addr_b  (rd_addr_b),
    .out_valid  (wr_en),
    .out_addr_a (wr_addr_a),
    .out_addr_b (wr_addr_b)
  );

endmodule

// File: tb/tb_fft_btf_sched.sv
// Directed bench for fft_btf_sched at N=8, BTF_LAT=3 with hand-derived tables.
module tb_fft_btf_sched;

  localparam int LOG2N   = 3;
  localparam int BTF_LAT = 3;
  localparam int P       = 8;
  localparam int LAST_WB = 3 * P;
`ifdef FFT_SCHED_BITREV_EN
  localparam int DONE_CYC = 33;
`else
  localparam int DONE_CYC = 25;
`endif

  logic             clk, rst_n, start, abort;
  logic             busy, done, rd_en, wr_en, ul_valid;
  logic [3:0]       stage;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, ul_addr, ul_idx;
  logic [LOG2N-2:0] tw_idx;

  int total = 0;
  int bad   = 0;

  int exp_ra [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int exp_rb [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int exp_tw [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  int exp_ul [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_btf_sched #(
    .LOG2N   (LOG2N),
    .BTF_LAT (BTF_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .ul_valid  (ul_valid),
    .ul_addr   (ul_addr),
    .ul_idx    (ul_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " rd_en"}, 32'(rd_en), 0);
    check({tag, " wr_en"}, 32'(wr_en), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_idle(tag);
    check({tag, " stage"}, 32'(stage), 0);
    check({tag, " rd_a"}, 32'(rd_addr_a), 0);
    check({tag, " rd_b"}, 32'(rd_addr_b), 0);
    check({tag, " tw"}, 32'(tw_idx), 0);
    check({tag, " wr_a"}, 32'(wr_addr_a), 0);
    check({tag, " wr_b"}, 32'(wr_addr_b), 0);
    check({tag, " ul_valid"}, 32'(ul_valid), 0);
    check({tag, " ul_addr"}, 32'(ul_addr), 0);
    check({tag, " ul_idx"}, 32'(ul_idx), 0);
  endtask

  // Entered in cycle 0 (IDLE); returns in the cycle after the done cycle.
  task automatic run_xform(input int abort_at, input int restart_at);
    int  s, off, idx;
    bit  aborted;
    aborted = 1'b0;
    start   = 1'b1;
    abort   = 1'b0;
    check("c0 busy", 32'(busy), 0);
    step();
    for (int c = 1; c <= DONE_CYC; c++) begin
      start = (c == restart_at);
      abort = (c == abort_at);
      if (aborted) begin
        check_idle($sformatf("aborted c%0d", c));
      end else if (c <= LAST_WB) begin
        s   = (c - 1) / P;
        off = (c - 1) % P;
        check($sformatf("busy c%0d", c), 32'(busy), 1);
        check($sformatf("done c%0d", c), 32'(done), 0);
        check($sformatf("stage c%0d", c), 32'(stage), 32'(s));
        check($sformatf("rd_en c%0d", c), 32'(rd_en), 32'(off < 4));
        check($sformatf("wr_en c%0d", c), 32'(wr_en), 32'(off >= 4));
        check($sformatf("ul_valid c%0d", c), 32'(ul_valid), 0);
        if (off < 4) begin
          idx = s * 4 + off;
          check($sformatf("rd_a c%0d", c), 32'(rd_addr_a), 32'(exp_ra[idx]));
          check($sformatf("rd_b c%0d", c), 32'(rd_addr_b), 32'(exp_rb[idx]));
          check($sformatf("tw c%0d", c), 32'(tw_idx), 32'(exp_tw[idx]));
        end else begin
          idx = s * 4 + off - 4;
          check($sformatf("wr_a c%0d", c), 32'(wr_addr_a), 32'(exp_ra[idx]));
          check($sformatf("wr_b c%0d", c), 32'(wr_addr_b), 32'(exp_rb[idx]));
        end
      end
`ifdef FFT_SCHED_BITREV_EN
      else if (c < DONE_CYC) begin
        check($sformatf("ul busy c%0d", c), 32'(busy), 1);
        check($sformatf("ul done c%0d", c), 32'(done), 0);
        check($sformatf("ul rd_en c%0d", c), 32'(rd_en), 0);
        check($sformatf("ul wr_en c%0d", c), 32'(wr_en), 0);
        check($sformatf("ul_valid c%0d", c), 32'(ul_valid), 1);
        check($sformatf("ul_idx c%0d", c), 32'(ul_idx), 32'(c - LAST_WB - 1));
        check($sformatf("ul_addr c%0d", c), 32'(ul_addr), 32'(exp_ul[c - LAST_WB - 1]));
      end
`endif
      else begin
        check($sformatf("done c%0d", c), 32'(done), 1);
        check($sformatf("done busy c%0d", c), 32'(busy), 1);
        check($sformatf("done rd_en c%0d", c), 32'(rd_en), 0);
        check($sformatf("done wr_en c%0d", c), 32'(wr_en), 0);
        check($sformatf("done ul_valid c%0d", c), 32'(ul_valid), 0);
      end
      if (c == abort_at) aborted = 1'b1;
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle("post reset");

    // Start re-asserted mid-transform is ignored; back-to-back start in cycle 26.
    run_xform(-1, 10);
    run_xform(-1, -1);

    // Abort and start together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort+start");
    step();
    check_idle("abort+start next");

    // Abort in cycle 14, then a clean transform.
    run_xform(14, -1);
    run_xform(-1, -1);

    // Asynchronous reset in cycle 6 while write-back is active.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre-rst wr_en", 32'(wr_en), 1);
    check("pre-rst busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid reset");
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_idle($sformatf("after reset %0d", i));
    end
    run_xform(-1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_btf_sched.md
# fft_btf_sched

Sequencer for a shared radix-2 butterfly unit running an in-place decimation-in-frequency (DIF) FFT over a 2^LOG2N-entry complex sample RAM. It issues one butterfly per cycle: RAM read addresses plus twiddle index. It regenerates the matching write-back addresses after the fixed read and butterfly latency, and drains the pipeline between stages to avoid read-after-write hazards. It sits between the FFT top level (start/done) and the sample RAM, butterfly and twiddle ROM. It replaces the per-butterfly start/ok counter handshake with a fully pipelined issue stream.

## Interface
- LOG2N, 3, log2 of FFT size N; legal range 2..10
- BTF_LAT, 3, butterfly latency in cycles from operands valid to results valid; must be ≥ 1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a transform; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE next cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- stage  out  4  current stage index 0..LOG2N-1
- rd_en  out  1  RAM read strobe; operands are valid to the butterfly the next cycle
- rd_addr_a / rd_addr_b  out  LOG2N  upper/lower butterfly leg addresses
- tw_idx  out  LOG2N-1  twiddle ROM index, aligned with rd_en
- wr_en  out  1  RAM write-back strobe for butterfly results
- wr_addr_a / wr_addr_b  out  LOG2N  write-back addresses
- ul_valid  out  1  unload strobe (FFT_SCHED_BITREV_EN only; tied 0 otherwise)
- ul_addr  out  LOG2N  RAM read address for unload
- ul_idx  out  LOG2N  natural-order output bin index for ul_addr

## Operation
- FSM states: IDLE, ISSUE, DRAIN, UNLOAD (macro only), DONE.
- IDLE, start=1 → ISSUE with stage=0 and k=g=0.
- ISSUE: rd_en=1 every cycle.
  - span = N>>(stage+1); groups = 1<<stage.
  - rd_addr_a = g·2·span + k; rd_addr_b = rd_addr_a + span; tw_idx = k<<stage.
  - k counts 0..span-1, then wraps and g increments. After N/2 issues → DRAIN.
- DRAIN: rd_en=0. Stay until the last write-back of the stage has been asserted.
  - Then, if stage < LOG2N-1: stage++ and → ISSUE.
  - Otherwise → UNLOAD (macro) or DONE.
- DONE: done=1 for one cycle → IDLE.
- Write-back pipeline: {rd_en, rd_addr_a, rd_addr_b} delayed exactly 1+BTF_LAT cycles drives {wr_en, wr_addr_a, wr_addr_b}.
- Address arithmetic is unsigned, LOG2N bits, with no overflow by construction. tw_idx is truncated to LOG2N-1 bits.
- start while busy is ignored.
- abort in any non-IDLE state:
  - → IDLE next cycle; busy drops, no done pulse.
  - The write-back pipeline is flushed, so wr_en is 0 from the next cycle.
- abort and start together in IDLE: abort wins and the FSM stays in IDLE.
- Asynchronous reset mid-transform has the same effect as abort, applied immediately.

## Timing
- Reset values: busy=0, done=0, stage=0, rd_en=0, wr_en=0, ul_valid=0, all address and index outputs 0.
- Reference cycle numbering: start sampled at edge 0, so cycle 0 is IDLE.
- Stage s issue window: rd_en high in cycles s·P+1 .. s·P+N/2, where P = N/2+1+BTF_LAT.
- Stage s write-back window: wr_en in cycles s·P+2+BTF_LAT .. (s+1)·P.
- The first rd_en of stage s+1 falls in the cycle immediately after the last wr_en of stage s.
- done is high in cycle LOG2N·P+1 without the macro, and LOG2N·P+N+1 with it.
- For N=8, BTF_LAT=3 (P=8):
  - rd_en in cycles 1–4, 9–12, 17–20.
  - wr_en in cycles 5–8, 13–16, 21–24.
  - done in cycle 25 without the macro, cycle 33 with it.
- busy is high from cycle 1 through the done cycle inclusive.

## Configuration
- FFT_SCHED_BITREV_EN defined:
  - After the final drain, UNLOAD runs for N cycles with ul_valid=1.
  - ul_idx counts 0..N-1; ul_addr = bit-reverse(ul_idx) over LOG2N bits.
  - DONE follows UNLOAD.
- Undefined:
  - No UNLOAD state; ul_valid, ul_addr and ul_idx are tied to 0.
  - DONE follows the final drain directly.

## Structure
- Shared package fft_pkg holds:
  - the state enum type;
  - the bitrev function (parameterised by width);
  - the STAGE_W=4 constant;
  - LOG2N range limits used by the elaboration checks.
- One sub-module, fft_wb_delay: a parameterised shift pipeline (depth 1+BTF_LAT) carrying {valid, addr_a, addr_b}, with a synchronous flush input driven by abort.
- Counters k, g, stage and the FSM stay in the top.

## Test plan
- N=8, BTF_LAT=3, start pulse at cycle 0:
  - rd_addr pairs (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3;
  - then (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2;
  - then (0,1),(2,3),(4,5),(6,7) with tw 0;
  - done in cycle 25.
- Write-back alignment: every wr_en/wr_addr pair equals the rd_en/rd_addr pair from 4 cycles earlier; no read of stage s+1 occurs before the final write of stage s.
- start re-asserted in cycle 10 while busy → ignored; sequence and done cycle unchanged. start in cycle 26 → new transform with first rd_en in cycle 27.
- abort in cycle 14 → busy=0 and wr_en=0 from cycle 15, no done pulse; a subsequent start runs a clean full transform.
- rst_n low in cycle 6 → all outputs at reset values immediately; after release, FSM is in IDLE with no spurious wr_en.
- FFT_SCHED_BITREV_EN, N=8 → ul_valid in cycles 25–32, ul_addr sequence 0,4,2,6,1,5,3,7, done in cycle 33.
